mem_stream_sequencer: RTL

Parametrised successor to the fixed 12-channel memory output mux. On each BX start pulse it emits one header word, then walks all NCHAN memories in order. For each memory it reads exactly the number of entries reported for that BX and streams every word tagged with a 1-based channel select. The output uses a valid/ready handshake and a 4-deep output FIFO, so downstream backpressure stalls memory reads without losing data.

---
 rtl/mem_stream_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stream_sequencer.sv
// Per-BX stream sequencer: one header word, then every reported entry of each
// memory channel tagged with its 1-based select, through a 4-deep valid/ready FIFO.
module mem_stream_sequencer #(
  parameter int NCHAN  = 12,
  parameter int DWIDTH = 40,
  parameter int SELW   = 5,
  parameter int BXW    = 3,
  parameter int NADDR  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BXW-1:0]          BX,
  input  logic [NCHAN*NADDR-1:0]  nent,
  output logic [NADDR-1:0]        rd_addr,
  output logic                    rd_en,
  output logic [SELW-1:0]         rd_sel,
  input  logic [NCHAN*DWIDTH-1:0] mem_dat,
  output logic [SELW+DWIDTH-1:0]  stream,
  output logic                    stream_valid,
  input  logic                    stream_ready,
  output logic                    busy,
  output logic                    trunc
);

  // state  | meaning
  // IDLE   | waiting for start
  // HEADER | pushing the header word, may also issue the first read
  // SCAN   | issuing reads over the nonzero channels
  // DONE   | waiting for the last read to land in the FIFO
  typedef enum logic [1:0] {IDLE, HEADER, SCAN, DONE} state_t;

  localparam int FDEPTH = 4;

  state_t                  state, state_nxt;
  logic [BXW-1:0]          bx_q;
  logic [NCHAN*NADDR-1:0]  nent_q;
  logic                    any_nz;
  logic [SELW-1:0]         cur_ch, nxt_ch, first_ch;
  logic                    nxt_found, first_found;
  logic [NADDR-1:0]        cur_addr, cur_cnt;
  logic                    last_addr;
  logic                    cap_vld;
  logic [SELW-1:0]         cap_sel;
  logic [DWIDTH-1:0]       cap_dat;
  logic [SELW+DWIDTH-1:0]  fifo_mem [FDEPTH];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              count;
  logic [3:0]              occ;
  logic                    hdr_push, dat_push, push, pop, flush, issue;
  logic [SELW+DWIDTH-1:0]  hdr_word, push_word;

  always_comb begin
    cur_cnt = '0;
    for (int c = 0; c < NCHAN; c++)
      if (cur_ch == SELW'(c)) cur_cnt = nent_q[c*NADDR +: NADDR];
  end

  // Descending scans so the lowest qualifying channel is the one that sticks.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int c = NCHAN-1; c >= 0; c--)
      if (SELW'(c) > cur_ch && nent_q[c*NADDR +: NADDR] != '0) begin
        nxt_found = 1'b1;
        nxt_ch    = SELW'(c);
      end
  end

  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    for (int c = NCHAN-1; c >= 0; c--)
      if (nent[c*NADDR +: NADDR] != '0) begin
        first_found = 1'b1;
        first_ch    = SELW'(c);
      end
  end

  always_comb begin
    cap_dat = '0;
    for (int c = 0; c < NCHAN; c++)
      if (cap_sel == SELW'(c+1)) cap_dat = mem_dat[c*DWIDTH +: DWIDTH];
  end

  assign last_addr = (cur_addr == cur_cnt - NADDR'(1));
  assign hdr_word  = {{SELW{1'b1}}, bx_q, {(DWIDTH-BXW){1'b0}}};
  // Occupancy the FIFO is already committed to: stored, landing now, landing next cycle.
  assign occ       = 4'(count) + 4'(cap_vld) + 4'(rd_en);
  assign flush     = start && (state != IDLE);
  assign dat_push  = cap_vld && !flush;
  assign push      = hdr_push || dat_push;
  assign push_word = hdr_push ? hdr_word : {cap_sel, cap_dat};
  assign pop       = stream_valid && stream_ready;

  always_comb begin
    state_nxt = state;
    hdr_push  = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      HEADER: begin
        if (count != 3'd4 && !cap_vld) begin
          hdr_push = 1'b1;
          if (!any_nz) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            issue     = (occ + 4'd1 < 4'd4);
          end
        end
      end
      SCAN: begin
        issue = (occ < 4'd4);
      end
      DONE: begin
        if (!rd_en && !cap_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (issue && last_addr && !nxt_found) state_nxt = DONE;
    if (start) begin
      state_nxt = HEADER;
      hdr_push  = 1'b0;
      issue     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bx_q     <= '0;
      nent_q   <= '0;
      any_nz   <= 1'b0;
      cur_ch   <= '0;
      cur_addr <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rd_sel   <= '0;
      cap_vld  <= 1'b0;
      cap_sel  <= '0;
      trunc    <= 1'b0;
    end else begin
      state   <= state_nxt;
      trunc   <= flush;
      rd_en   <= issue;
      rd_addr <= issue ? cur_addr : '0;
      rd_sel  <= issue ? cur_ch + SELW'(1) : '0;
      cap_vld <= rd_en && !flush;
      cap_sel <= rd_sel;
      if (start) begin
        bx_q     <= BX;
        nent_q   <= nent;
        any_nz   <= first_found;
        cur_ch   <= first_ch;
        cur_addr <= '0;
      end else if (issue) begin
        if (last_addr) begin
          cur_ch   <= nxt_ch;
          cur_addr <= '0;
        end else begin
          cur_addr <= cur_addr + NADDR'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  assign stream_valid = (count != 3'd0);
  assign stream       = stream_valid ? fifo_mem[rd_ptr] : '0;
  assign busy         = (state != IDLE) || stream_valid;

endmodule
